// File: rtl/alarm_scheduler.sv
// alarm_scheduler: periodic alarm sequencer with beep pattern, ack, snooze.
// Owns the interval register, matches on BCD mm:ss, rotates one-hot LEDs.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   tick_1hz            1-cycle pulse per seconds increment
//   minutes, seconds    BCD time, [7:4] tens, [3:0] ones
//   enable              alarm enable, low aborts any activity
//   cfg_we/cfg_interval interval write (binary minutes, 1..59 accepted)
//   ack, snooze         level requests, sampled every cycle
//   buzzer_n            buzzer, active low
//   leds, led_index     one-hot indicator and its slot (0..6)
//   busy                high outside IDLE
//   interval_q          current interval register
//
// Option macro ALARM_SCHEDULER_LED_BLINK_EN: LED lit only while the
// buzzer sounds (RING_ON); otherwise the LED is steady for the alarm.

module alarm_scheduler #(
   parameter int BEEP_COUNT       = 4,
   parameter int SNOOZE_MIN       = 5,
   parameter int DEFAULT_INTERVAL = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic [7:0] minutes,
   input  logic [7:0] seconds,
   input  logic       enable,
   input  logic       cfg_we,
   input  logic [5:0] cfg_interval,
   input  logic       ack,
   input  logic       snooze,
   output logic       buzzer_n,
   output logic [6:0] leds,
   output logic [2:0] led_index,
   output logic       busy,
   output logic [5:0] interval_q
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RING_ON,
      S_RING_OFF,
      S_SNOOZE
   } state_e;

   localparam logic [3:0] LAST_BEEP    = 4'(BEEP_COUNT - 1);
   localparam logic [9:0] SNOOZE_TICKS = 10'(SNOOZE_MIN * 60);
   localparam logic [5:0] INTERVAL_RST = 6'(DEFAULT_INTERVAL);

`ifdef ALARM_SCHEDULER_LED_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   state_e     state_q;
   logic       buzzer_n_q;
   logic [6:0] leds_q;
   logic [2:0] led_index_q;
   logic       busy_q;
   logic [5:0] interval_reg_q;
   logic [3:0] beep_cnt_q;
   logic [9:0] snooze_cnt_q;

   logic [6:0] min_bin;
   logic [6:0] min_rem;
   logic       cfg_ok;
   logic       match;
   logic [6:0] led_on;
   logic [6:0] led_quiet;
   logic [2:0] led_next;

   function automatic logic [6:0] onehot(input logic [2:0] i);
      logic [6:0] one;
      one = 7'd1;
      return one << i;
   endfunction

   always_comb begin
      min_bin   = 7'({3'b000, minutes[7:4]} * 7'd10)
                + {3'b000, minutes[3:0]};
      // interval_q is never 0, so the modulo is always defined
      min_rem   = min_bin % {1'b0, interval_reg_q};
      match     = tick_1hz & enable & (seconds == 8'h00)
                & (min_rem == 7'd0);
      cfg_ok    = (cfg_interval != 6'd0) && (cfg_interval <= 6'd59);
      led_on    = onehot(led_index_q);
      led_quiet = BLINK ? 7'd0 : led_on;
      led_next  = (led_index_q == 3'd6) ? 3'd0 : led_index_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         buzzer_n_q     <= 1'b1;
         leds_q         <= 7'd0;
         led_index_q    <= 3'd6;
         busy_q         <= 1'b0;
         interval_reg_q <= INTERVAL_RST;
         beep_cnt_q     <= 4'd0;
         snooze_cnt_q   <= 10'd0;
      end else begin
         // match above still sees the old interval this cycle
         if (cfg_we && cfg_ok)
            interval_reg_q <= cfg_interval;

         if (!enable) begin
            state_q    <= S_IDLE;
            buzzer_n_q <= 1'b1;
            leds_q     <= 7'd0;
            busy_q     <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (match) begin
                     state_q    <= S_RING_ON;
                     beep_cnt_q <= 4'd0;
                     buzzer_n_q <= 1'b0;
                     leds_q     <= led_on;
                     busy_q     <= 1'b1;
                  end
               end
               S_RING_ON: begin
                  if (ack) begin
                     state_q     <= S_IDLE;
                     buzzer_n_q  <= 1'b1;
                     leds_q      <= 7'd0;
                     busy_q      <= 1'b0;
                     led_index_q <= led_next;
                  end else if (snooze) begin
                     state_q      <= S_SNOOZE;
                     snooze_cnt_q <= SNOOZE_TICKS;
                     buzzer_n_q   <= 1'b1;
                     leds_q       <= led_quiet;
                  end else if (tick_1hz) begin
                     state_q    <= S_RING_OFF;
                     buzzer_n_q <= 1'b1;
                     leds_q     <= led_quiet;
                  end
               end
               S_RING_OFF: begin
                  if (ack) begin
                     state_q     <= S_IDLE;
                     buzzer_n_q  <= 1'b1;
                     leds_q      <= 7'd0;
                     busy_q      <= 1'b0;
                     led_index_q <= led_next;
                  end else if (snooze) begin
                     state_q      <= S_SNOOZE;
                     snooze_cnt_q <= SNOOZE_TICKS;
                     buzzer_n_q   <= 1'b1;
                     leds_q       <= led_quiet;
                  end else if (tick_1hz) begin
                     if (beep_cnt_q == LAST_BEEP) begin
                        state_q     <= S_IDLE;
                        leds_q      <= 7'd0;
                        busy_q      <= 1'b0;
                        led_index_q <= led_next;
                     end else begin
                        state_q    <= S_RING_ON;
                        beep_cnt_q <= beep_cnt_q + 4'd1;
                        buzzer_n_q <= 1'b0;
                        leds_q     <= led_on;
                     end
                  end
               end
               S_SNOOZE: begin
                  // a repeated snooze request here is a no-op
                  if (ack) begin
                     state_q     <= S_IDLE;
                     buzzer_n_q  <= 1'b1;
                     leds_q      <= 7'd0;
                     busy_q      <= 1'b0;
                     led_index_q <= led_next;
                  end else if (tick_1hz) begin
                     if (snooze_cnt_q == 10'd1) begin
                        state_q    <= S_RING_ON;
                        beep_cnt_q <= 4'd0;
                        buzzer_n_q <= 1'b0;
                        leds_q     <= led_on;
                     end else begin
                        snooze_cnt_q <= snooze_cnt_q - 10'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign buzzer_n   = buzzer_n_q;
   assign leds       = leds_q;
   assign led_index  = led_index_q;
   assign busy       = busy_q;
   assign interval_q = interval_reg_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: directed scoreboard bench for alarm_scheduler.
// Packs {buzzer_n, leds, led_index, busy, interval_q} per check.

module tb_alarm_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz;
   logic [7:0] minutes;
   logic [7:0] seconds;
   logic       enable;
   logic       cfg_we;
   logic [5:0] cfg_interval;
   logic       ack;
   logic       snooze;
   logic       buzzer_n;
   logic [6:0] leds;
   logic [2:0] led_index;
   logic       busy;
   logic [5:0] interval_q;

   int n_cmp = 0;
   int n_err = 0;
   logic [17:0] sb_q[$];

   alarm_scheduler #(
      .BEEP_COUNT(4),
      .SNOOZE_MIN(5),
      .DEFAULT_INTERVAL(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tick_1hz(tick_1hz),
      .minutes(minutes),
      .seconds(seconds),
      .enable(enable),
      .cfg_we(cfg_we),
      .cfg_interval(cfg_interval),
      .ack(ack),
      .snooze(snooze),
      .buzzer_n(buzzer_n),
      .leds(leds),
      .led_index(led_index),
      .busy(busy),
      .interval_q(interval_q)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] ev(input logic b,
                                      input logic [6:0] l,
                                      input logic [2:0] i,
                                      input logic bz,
                                      input logic [5:0] iv);
      return {b, l, i, bz, iv};
   endfunction

   function automatic logic [6:0] oh(input logic [2:0] i);
      logic [6:0] one;
      one = 7'd1;
      return one << i;
   endfunction

   task automatic push(input logic [17:0] e);
      sb_q.push_back(e);
   endtask

   task automatic cmp(input string tag);
      logic [17:0] obs;
      logic [17:0] e;
      obs = {buzzer_n, leds, led_index, busy, interval_q};
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         e = sb_q.pop_front();
         n_cmp++;
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick_at(input logic [7:0] sec);
      seconds  = sec;
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      step(1);
      ack = 1'b0;
   endtask

   task automatic write_cfg(input logic [5:0] v);
      cfg_we       = 1'b1;
      cfg_interval = v;
      step(1);
      cfg_we       = 1'b0;
   endtask

   initial begin
      logic [2:0] idx;
      rst_n        = 1'b0;
      tick_1hz     = 1'b0;
      minutes      = 8'h12;
      seconds      = 8'h00;
      enable       = 1'b1;
      cfg_we       = 1'b0;
      cfg_interval = 6'd0;
      ack          = 1'b0;
      snooze       = 1'b0;
      step(2);
      push(ev(1'b1, 7'd0, 3'd6, 1'b0, 6'd1));
      cmp("reset");
      rst_n = 1'b1;
      step(1);

      // first alarm at 12:00, interval 1
      push(ev(1'b0, 7'h40, 3'd6, 1'b1, 6'd1));
      tick_at(8'h00);
      cmp("ring_start");
      push(ev(1'b1, 7'h40, 3'd6, 1'b1, 6'd1));
      tick_at(8'h01);
      cmp("ring_off1");
      repeat (6) tick_at(8'h01);
      push(ev(1'b1, 7'h40, 3'd6, 1'b1, 6'd1));
      cmp("ring_off4");
      push(ev(1'b1, 7'h00, 3'd0, 1'b0, 6'd1));
      tick_at(8'h01);
      cmp("ring_done");

      // interval register
      push(ev(1'b1, 7'h00, 3'd0, 1'b0, 6'd15));
      write_cfg(6'd15);
      cmp("cfg15");
      minutes = 8'h14;
      push(ev(1'b1, 7'h00, 3'd0, 1'b0, 6'd15));
      tick_at(8'h00);
      cmp("no_match_14");
      push(ev(1'b1, 7'h00, 3'd0, 1'b0, 6'd15));
      write_cfg(6'd0);
      cmp("cfg0_ignored");
      push(ev(1'b1, 7'h00, 3'd0, 1'b0, 6'd15));
      write_cfg(6'd60);
      cmp("cfg60_ignored");
      minutes = 8'h30;
      push(ev(1'b0, 7'h01, 3'd0, 1'b1, 6'd15));
      tick_at(8'h00);
      cmp("match_30");

      // ack in RING_ON
      push(ev(1'b1, 7'h00, 3'd1, 1'b0, 6'd15));
      pulse_ack();
      cmp("ack_ring_on");

      // ack beats tick in the same cycle
      push(ev(1'b0, 7'h02, 3'd1, 1'b1, 6'd15));
      tick_at(8'h00);
      cmp("ring_idx1");
      push(ev(1'b1, 7'h00, 3'd2, 1'b0, 6'd15));
      ack = 1'b1;
      tick_at(8'h01);
      ack = 1'b0;
      cmp("ack_vs_tick");

      // snooze during second beep
      push(ev(1'b0, 7'h04, 3'd2, 1'b1, 6'd15));
      tick_at(8'h00);
      cmp("ring_idx2");
      tick_at(8'h01);
      tick_at(8'h01);
      push(ev(1'b1, 7'h04, 3'd2, 1'b1, 6'd15));
      snooze = 1'b1;
      step(1);
      snooze = 1'b0;
      cmp("snooze_enter");
      for (int i = 0; i < 299; i++) begin
         tick_at(8'h01);
         if (i == 100) begin
            snooze = 1'b1;
            step(1);
            snooze = 1'b0;
         end
      end
      push(ev(1'b1, 7'h04, 3'd2, 1'b1, 6'd15));
      cmp("snooze_299");
      push(ev(1'b0, 7'h04, 3'd2, 1'b1, 6'd15));
      tick_at(8'h01);
      cmp("snooze_wake");
      repeat (7) tick_at(8'h01);
      push(ev(1'b1, 7'h04, 3'd2, 1'b1, 6'd15));
      cmp("fresh_beeps");
      push(ev(1'b1, 7'h00, 3'd3, 1'b0, 6'd15));
      tick_at(8'h01);
      cmp("fresh_done");

      // enable low mid-SNOOZE
      push(ev(1'b0, 7'h08, 3'd3, 1'b1, 6'd15));
      tick_at(8'h00);
      cmp("ring_idx3");
      snooze = 1'b1;
      step(1);
      snooze = 1'b0;
      push(ev(1'b1, 7'h00, 3'd3, 1'b0, 6'd15));
      enable = 1'b0;
      step(1);
      enable = 1'b1;
      cmp("enable_abort");

      // reset, then rotate through 7 alarms
      rst_n = 1'b0;
      step(1);
      push(ev(1'b1, 7'h00, 3'd6, 1'b0, 6'd1));
      cmp("reset2");
      rst_n   = 1'b1;
      minutes = 8'h12;
      step(1);
      idx = 3'd6;
      for (int k = 0; k < 7; k++) begin
         push(ev(1'b0, oh(idx), idx, 1'b1, 6'd1));
         tick_at(8'h00);
         cmp("rot_ring");
         idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
         push(ev(1'b1, 7'h00, idx, 1'b0, 6'd1));
         pulse_ack();
         cmp("rot_ack");
      end

      // async reset mid-ring
      tick_at(8'h00);
      pulse_ack();
      push(ev(1'b0, 7'h01, 3'd0, 1'b1, 6'd1));
      tick_at(8'h00);
      cmp("ring_pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      push(ev(1'b1, 7'h00, 3'd6, 1'b0, 6'd1));
      cmp("async_reset");
      step(1);
      rst_n = 1'b1;
      step(1);

      // match while ringing does not restart
      push(ev(1'b0, 7'h40, 3'd6, 1'b1, 6'd1));
      tick_at(8'h00);
      cmp("ring_again");
      push(ev(1'b1, 7'h40, 3'd6, 1'b1, 6'd1));
      tick_at(8'h00);
      cmp("no_restart");
      repeat (6) tick_at(8'h00);
      push(ev(1'b1, 7'h40, 3'd6, 1'b1, 6'd1));
      cmp("no_restart_off4");
      push(ev(1'b1, 7'h00, 3'd0, 1'b0, 6'd1));
      tick_at(8'h00);
      cmp("no_restart_done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Sequences the periodic alarm for the clock datapath.
- Owns the alarm interval register and detects interval matches on the BCD minutes/seconds time.
- Runs a timed beep pattern on the active-low buzzer, with acknowledge and snooze.
- Drives the 7-LED one-hot indicator, which rotates after each completed or acknowledged alarm.

Parameters:
- BEEP_COUNT, 4, number of 1 s on / 1 s off beep pairs per alarm (1..15).
- SNOOZE_MIN, 5, snooze length in minutes (1..9).
- DEFAULT_INTERVAL, 1, interval register reset value in minutes (1..59).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-cycle pulse, coincident with each seconds increment.
- minutes  in  8  BCD minutes, [7:4] tens, [3:0] ones.
- seconds  in  8  BCD seconds, same format.
- enable  in  1  alarm enable; low aborts any activity.
- cfg_we  in  1  interval write strobe.
- cfg_interval  in  6  new interval, binary minutes.
- ack  in  1  acknowledge (level, sampled each cycle).
- snooze  in  1  snooze request (level, sampled each cycle).
- buzzer_n  out  1  buzzer, active low.
- leds  out  7  one-hot LED indicator.
- led_index  out  3  current LED slot, 0..6.
- busy  out  1  high in any state other than IDLE.
- interval_q  out  6  current interval register value.

Behaviour:
- Reset values (async, rst_n low):
  - state IDLE, buzzer_n=1, leds=0, led_index=6, busy=0.
  - interval_q=DEFAULT_INTERVAL, beep_cnt=0, snooze_cnt=0.
- Interval register:
  - Loaded from cfg_interval on cfg_we when the value is 1..59; 0 or >59 is ignored (no change).
  - Writable in any state; takes effect from the next match evaluation.
- BCD to binary: min_bin = tens*10 + ones, 7-bit. Same conversion for seconds.
- match = tick_1hz & enable & (seconds == 8'h00) & (min_bin % interval_q == 0).
- State machine (all outputs registered):
  - IDLE: buzzer_n=1, leds=0.
    - On match -> RING_ON next edge; beep_cnt=0; leds=onehot(led_index).
    - Latency is 1 clk from the match tick to buzzer_n low.
  - RING_ON: buzzer_n=0. On tick_1hz -> RING_OFF.
  - RING_OFF: buzzer_n=1. On tick_1hz:
    - if beep_cnt==BEEP_COUNT-1 -> IDLE and led_index advances;
    - else beep_cnt+1 -> RING_ON.
  - SNOOZE: buzzer_n=1.
    - snooze_cnt is loaded with SNOOZE_MIN*60 on entry (10-bit) and decrements on each tick_1hz.
    - On the tick where snooze_cnt==1 -> RING_ON, beep_cnt=0.
- led_index advance: 6 wraps to 0, otherwise +1. Occurs exactly once per alarm, on exit to IDLE by completion or ack.
- leds hold onehot(led_index) through RING_ON, RING_OFF and SNOOZE; 0 in IDLE.
- Priority, highest first, in the same cycle: enable low > ack > snooze > tick_1hz.
  - enable low in any state: -> IDLE, leds=0, buzzer_n=1, no led_index advance.
  - ack in RING_ON, RING_OFF or SNOOZE: -> IDLE, with led_index advance.
  - snooze in RING_ON or RING_OFF: -> SNOOZE. snooze while already in SNOOZE does not reload the counter.
- A match while not in IDLE is ignored; there is no queuing.
- A match coincident with cfg_we uses the old interval.
- Reset mid-ring: immediate silence, led_index returns to 6.

Optional Feature:
- Macro: ALARM_SCHEDULER_LED_BLINK_EN.
- Defined:
  - leds = onehot(led_index) only in RING_ON; 0 in RING_OFF and SNOOZE.
  - The LED flashes in phase with the buzzer.
- Undefined: leds are steady as described in Behaviour.

Test Plan:
- Reset, interval_q=1, minutes=8'h12, seconds=8'h00, tick -> 1 clk later buzzer_n=0, leds=7'b1000000, busy=1. After 8 ticks (BEEP_COUNT=4): IDLE, led_index=0, leds=0.
- cfg_interval=15 written. Ticks at 8'h14:00 -> no response. Ticks at 8'h30:00 -> ring starts. cfg_interval=0 and cfg_interval=60 writes -> interval_q stays 15.
- Ring in progress, assert ack in RING_ON -> next clk buzzer_n=1, busy=0, led_index increments by 1. Ack and tick in the same cycle -> ack wins.
- Snooze during second beep, SNOOZE_MIN=5 -> buzzer_n=1 for exactly 300 ticks, then RING_ON with a fresh 4-beep pattern; leds held throughout.
- Drop enable mid-SNOOZE -> IDLE within 1 clk, no led_index change. Rotate through 7 alarms -> led_index sequence 6,0,1,...,5.
- Assert rst_n low during RING_ON -> buzzer_n=1 and leds=0 asynchronously, led_index=6. A match during ringing -> no restart.
